lenet_stage_sequencer: RTL and testbench
========================================

// Module: lenet_stage_sequencer
// PURPOSE
//  Flow-control sequencer for the 4-register LeNet pipeline: S0 image_buffer, S1 conv2_featuremap,
//  S2 conv3_featuremap, S3 output_vector. Drives per-stage load enables and waits a programmed
//  settle time across each combinational layer group. Up to 4 frames in flight.
//  Valid/ready handshake at the image input and the result output; a tag travels with each frame.
// PARAMETERS
//  SETTLE1  2   cycles S0 must hold before S1 may load (conv1+actv1+maxp1 path)
//  SETTLE2  2   cycles S1 must hold before S2 may load (conv2+actv2+maxp2 path)
//  SETTLE3  3   cycles S2 must hold before S3 may load (conv3+actv3+fc path)
//  CNT_W    4   settle counter width; must hold max(SETTLEk)
//  TAG_W    4   frame tag width
// PORTS
//  clk          in   1      clock
//  reset_n      in   1      asynchronous active-low reset
//  in_valid     in   1      image + tag present
//  in_tag       in   TAG_W  frame tag
//  in_ready     out  1      S0 accepts this cycle
//  flush        in   1      synchronous: drop all frames in flight
//  load_en      out  4      bit k = stage k register captures on this edge
//  out_valid    out  1      S3 holds a valid result
//  out_tag      out  TAG_W  tag of the S3 frame
//  out_ready    in   1      consumer takes the result
//  busy         out  1      any stage valid
//  perf_frames  out  32     frames delivered (LENET_SEQ_PERF_EN)
//  perf_stalls  out  32     cycles out_valid & !out_ready (LENET_SEQ_PERF_EN)
// BEHAVIOUR
//  - Reset: v[3:0]=0, cnt[k]=0, tags=0, perf=0. Outputs: in_ready=1, load_en=0, out_valid=0, busy=0.
//  - State per stage k: v[k], cnt[k] (saturates at SETTLE(k+1); S3 has no cnt), tag[k].
//  - adv3 = v[3] & out_ready (drain).
//    adv_k (k<3) = v[k] & cnt[k]==SETTLE(k+1) & (!v[k+1] | adv(k+1)).
//    Evaluate from S3 down to S0, combinationally in one cycle. A full pipe shifts in lockstep.
//  - load_en[0] = in_valid & in_ready; in_ready = !v[0] | adv0. load_en[k] = adv(k-1) for k=1..3.
//  - On stage k load: v[k]<=1, cnt[k]<=0, tag[k]<=upstream tag.
//    If stage k advances without a load: v[k]<=0.
//    If load and advance happen together, the load wins (v stays 1, cnt restarts).
//  - Counters increment each cycle while v[k]=1 and cnt < limit. The counter does not wrap.
//  - Latency: a frame accepted at edge e0 gives out_valid after edge e0+SETTLE1+SETTLE2+SETTLE3+3
//    (defaults: 10) with no backpressure.
//  - Throughput: one frame per max(SETTLEk)+1 cycles (defaults: 4).
//  - out_valid=v[3]; out_tag=tag[3]. The result holds stable until out_ready. No combinational
//    path from out_ready to out_valid; the out_ready->in_ready ripple is allowed.
//  - flush: next edge clears all v and cnt; load_en=0 and in_ready=0 in the flush cycle.
//    Flush has priority over every load and drain; perf counters are not cleared.
//  - reset_n asserted mid-frame: the frame is lost immediately; state is the reset state.
//  - SETTLEk=0 is legal: the downstream load can happen the edge after the upstream load.
// CONFIGURATION
//  LENET_SEQ_PERF_EN defined:
//    perf_frames += 1 per out_valid&out_ready;
//    perf_stalls += 1 per out_valid&!out_ready; both wrap at 2^32.
//  Undefined: both ports tied to 0; no counter flops are synthesised.
// STRUCTURE
//  - Package lenet_pkg: NUM_STAGES=4, stage index enum (ST_IMG, ST_C2, ST_C3, ST_OUT),
//    typedef stage_vec_t logic[NUM_STAGES-1:0].
//  - One sub-module: lenet_stage_slot (v, cnt, tag, adv logic for one stage; limit as parameter),
//    instantiated for S0..S2. S3 is inline.
// TESTING
//  1 Single frame, tag=5, out_ready=1
//    -> load_en pulses 0001, 0010, 0100, 1000 at edges 0, 3, 6, 10; out_valid at edge 10; out_tag=5.
//  2 Continuous in_valid, out_ready=1, tags 0..7
//    -> in_ready 1 of every 4 cycles; outputs in order 0..7, spaced 4 cycles apart.
//  3 out_ready=0, inject 6 frames -> 4 accepted, then in_ready=0; busy=1; out_valid held, tag stable.
//    Then release -> remaining frames drain in order.
//  4 flush with 3 frames in flight -> next cycle v=0, out_valid=0, busy=0, in_ready=1; load_en=0 in the flush cycle.
//  5 reset_n low mid-flight, asynchronous between edges -> outputs reach reset values at once.
//    After release, a new frame has latency 10.
//  6 PERF_EN with 2 frames, 3 stall cycles -> perf_frames=2, perf_stalls=3.
//    Without the macro -> both 0.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet stage sequencer: stage count, stage
// index names and the per-stage bit-vector type.
package lenet_pkg;

  localparam int NUM_STAGES = 4;

  typedef enum logic [1:0] {
    ST_IMG = 2'd0,
    ST_C2  = 2'd1,
    ST_C3  = 2'd2,
    ST_OUT = 2'd3
  } stage_e;

  typedef logic [NUM_STAGES-1:0] stage_vec_t;

endpackage

// File: rtl/lenet_stage_slot.sv
// One pipeline stage slot: valid flag, saturating settle counter and frame
// tag. The stage may hand its frame downstream once the counter has reached
// LIMIT and the downstream stage is empty or emptying in the same cycle.
module lenet_stage_slot #(
  parameter int LIMIT = 2,
  parameter int CNT_W = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             down_v_i,
  input  logic             down_adv_i,
  output logic             v_o,
  output logic             adv_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic             v_q, v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  assign adv_o = v_q & (cnt_q == LIM) & (~down_v_i | down_adv_i);
  assign v_o   = v_q;
  assign tag_o = tag_q;

  // Next state: flush beats load, load beats advance (back-to-back refill).
  always_comb begin
    v_d   = v_q;
    cnt_d = cnt_q;
    tag_d = tag_q;
    if (flush_i) begin
      v_d   = 1'b0;
      cnt_d = '0;
    end else if (load_i) begin
      v_d   = 1'b1;
      cnt_d = '0;
      tag_d = tag_i;
    end else if (adv_o) begin
      v_d   = 1'b0;
      cnt_d = '0;
    end else if (v_q && (cnt_q < LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Stage state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q   <= 1'b0;
      cnt_q <= '0;
      tag_q <= '0;
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
      tag_q <= tag_d;
    end
  end

endmodule

// File: rtl/lenet_stage_sequencer.sv
// Flow-control sequencer for the four-register LeNet pipeline
// (S0 image buffer, S1 conv2 map, S2 conv3 map, S3 output vector).
// Advances ripple from S3 down to S0 in one cycle so a full pipe shifts in
// lockstep. Optional perf counters are built when LENET_SEQ_PERF_EN is
// defined; otherwise perf_frames/perf_stalls are tied to zero.
module lenet_stage_sequencer
  import lenet_pkg::*;
#(
  parameter int SETTLE1 = 2,
  parameter int SETTLE2 = 2,
  parameter int SETTLE3 = 3,
  parameter int CNT_W   = 4,
  parameter int TAG_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [NUM_STAGES-1:0] load_en,
  output logic                  out_valid,
  output logic [TAG_W-1:0]      out_tag,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [31:0]           perf_frames,
  output logic [31:0]           perf_stalls
);

  logic             v_img, v_c2, v_c3, v_out_q;
  logic             adv_img, adv_c2, adv_c3, adv_out;
  logic             ld_img, ld_c2, ld_c3, ld_out;
  logic [TAG_W-1:0] tag_img, tag_c2, tag_c3, tag_out_q;
  stage_vec_t       ld_vec, v_vec;

  assign adv_out  = v_out_q & out_ready;
  assign in_ready = ~flush & (~v_img | adv_img);
  assign ld_img   = in_valid & in_ready;
  assign ld_c2    = adv_img & ~flush;
  assign ld_c3    = adv_c2 & ~flush;
  assign ld_out   = adv_c3 & ~flush;

  // Gather per-stage loads and valids into stage-indexed vectors.
  always_comb begin
    ld_vec         = '0;
    v_vec          = '0;
    ld_vec[ST_IMG] = ld_img;
    ld_vec[ST_C2]  = ld_c2;
    ld_vec[ST_C3]  = ld_c3;
    ld_vec[ST_OUT] = ld_out;
    v_vec[ST_IMG]  = v_img;
    v_vec[ST_C2]   = v_c2;
    v_vec[ST_C3]   = v_c3;
    v_vec[ST_OUT]  = v_out_q;
  end

  assign load_en   = ld_vec;
  assign busy      = |v_vec;
  assign out_valid = v_out_q;
  assign out_tag   = tag_out_q;

  lenet_stage_slot #(.LIMIT(SETTLE1), .CNT_W(CNT_W), .TAG_W(TAG_W)) u_slot_img (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush_i    (flush),
    .load_i     (ld_img),
    .tag_i      (in_tag),
    .down_v_i   (v_c2),
    .down_adv_i (adv_c2),
    .v_o        (v_img),
    .adv_o      (adv_img),
    .tag_o      (tag_img)
  );

  lenet_stage_slot #(.LIMIT(SETTLE2), .CNT_W(CNT_W), .TAG_W(TAG_W)) u_slot_c2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush_i    (flush),
    .load_i     (ld_c2),
    .tag_i      (tag_img),
    .down_v_i   (v_c3),
    .down_adv_i (adv_c3),
    .v_o        (v_c2),
    .adv_o      (adv_c2),
    .tag_o      (tag_c2)
  );

  lenet_stage_slot #(.LIMIT(SETTLE3), .CNT_W(CNT_W), .TAG_W(TAG_W)) u_slot_c3 (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush_i    (flush),
    .load_i     (ld_c3),
    .tag_i      (tag_c2),
    .down_v_i   (v_out_q),
    .down_adv_i (adv_out),
    .v_o        (v_c3),
    .adv_o      (adv_c3),
    .tag_o      (tag_c3)
  );

  // Output stage: result is held stable until the consumer accepts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_out_q   <= 1'b0;
      tag_out_q <= '0;
    end else if (flush) begin
      v_out_q   <= 1'b0;
    end else if (ld_out) begin
      v_out_q   <= 1'b1;
      tag_out_q <= tag_c3;
    end else if (adv_out) begin
      v_out_q   <= 1'b0;
    end
  end

`ifdef LENET_SEQ_PERF_EN
  logic [31:0] perf_frames_q, perf_stalls_q;

  // Delivered-frame and output-stall counters; free-running, wrap at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_frames_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (v_out_q & out_ready)  perf_frames_q <= perf_frames_q + 32'd1;
      if (v_out_q & ~out_ready) perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_frames = perf_frames_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_frames = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_lenet_stage_sequencer.sv
// Self-checking bench for lenet_stage_sequencer (default parameters).
module tb_lenet_stage_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_tag = 4'd0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [3:0]  load_en, out_tag;
  logic [31:0] perf_frames, perf_stalls;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lenet_stage_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_tag      (in_tag),
    .in_ready    (in_ready),
    .flush       (flush),
    .load_en     (load_en),
    .out_valid   (out_valid),
    .out_tag     (out_tag),
    .out_ready   (out_ready),
    .busy        (busy),
    .perf_frames (perf_frames),
    .perf_stalls (perf_stalls)
  );

  typedef struct {
    logic       iv;
    logic [3:0] itag;
    logic       ordy;
    logic       fl;
    logic       e_irdy;
    logic [3:0] e_ld;
    logic       e_ov;
    logic [3:0] e_otag;
    logic       e_busy;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(logic iv, logic [3:0] itag, logic ordy, logic fl,
                              logic irdy, logic [3:0] ld, logic ov, logic [3:0] otag,
                              logic bsy);
    vec_t r;
    r.iv = iv; r.itag = itag; r.ordy = ordy; r.fl = fl;
    r.e_irdy = irdy; r.e_ld = ld; r.e_ov = ov; r.e_otag = otag; r.e_busy = bsy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, recv, cyc, last_out, n;
    int acc_cyc [8];
    logic stable_bad;
    logic [31:0] exp_frames, exp_stalls;

    // Test 1 (rows 0-12): single frame, tag 5. Test 4 (rows 13-24): flush with 3 in flight.
    vecs[0]  = mk(1'b1, 4'd5, 1'b1, 1'b0,  1'b1, 4'b0001, 1'b0, 4'd0, 1'b0);
    vecs[1]  = mk(1'b0, 4'd0, 1'b1, 1'b0,  1'b0, 4'b0000, 1'b0, 4'd0, 1'b1);
    vecs[2]  = mk(1'b0, 4'd0, 1'b1, 1'b0,  1'b0, 4'b0000, 1'b0, 4'd0, 1'b1);
    vecs[3]  = mk(1'b0, 4'd0, 1'b1, 1'b0,  1'b1, 4'b0010, 1'b0, 4'd0, 1'b1);
    vecs[4]  = mk(1'b0, 4'd0, 1'b1, 1'b0,  1'b1, 4'b0000, 1'b0, 4'd0, 1'b1);
    vecs[5]  = mk(1'b0, 4'd0, 1'b1, 1'b0,  1'b1, 4'b0000, 1'b0, 4'd0, 1'b1);
    vecs[6]  = mk(1'b0, 4'd0, 1'b1, 1'b0,  1'b1, 4'b0100, 1'b0, 4'd0, 1'b1);
    vecs[7]  = mk(1'b0, 4'd0, 1'b1, 1'b0,  1'b1, 4'b0000, 1'b0, 4'd0, 1'b1);
    vecs[8]  = mk(1'b0, 4'd0, 1'b1, 1'b0,  1'b1, 4'b0000, 1'b0, 4'd0, 1'b1);
    vecs[9]  = mk(1'b0, 4'd0, 1'b1, 1'b0,  1'b1, 4'b0000, 1'b0, 4'd0, 1'b1);
    vecs[10] = mk(1'b0, 4'd0, 1'b1, 1'b0,  1'b1, 4'b1000, 1'b0, 4'd0, 1'b1);
    vecs[11] = mk(1'b0, 4'd0, 1'b1, 1'b0,  1'b1, 4'b0000, 1'b1, 4'd5, 1'b1);
    vecs[12] = mk(1'b0, 4'd0, 1'b1, 1'b0,  1'b1, 4'b0000, 1'b0, 4'd0, 1'b0);
    vecs[13] = mk(1'b1, 4'd1, 1'b1, 1'b0,  1'b1, 4'b0001, 1'b0, 4'd0, 1'b0);
    vecs[14] = mk(1'b1, 4'd2, 1'b1, 1'b0,  1'b0, 4'b0000, 1'b0, 4'd0, 1'b1);
    vecs[15] = mk(1'b1, 4'd2, 1'b1, 1'b0,  1'b0, 4'b0000, 1'b0, 4'd0, 1'b1);
    vecs[16] = mk(1'b1, 4'd2, 1'b1, 1'b0,  1'b1, 4'b0011, 1'b0, 4'd0, 1'b1);
    vecs[17] = mk(1'b1, 4'd3, 1'b1, 1'b0,  1'b0, 4'b0000, 1'b0, 4'd0, 1'b1);
    vecs[18] = mk(1'b1, 4'd3, 1'b1, 1'b0,  1'b0, 4'b0000, 1'b0, 4'd0, 1'b1);
    vecs[19] = mk(1'b1, 4'd3, 1'b1, 1'b0,  1'b1, 4'b0111, 1'b0, 4'd0, 1'b1);
    vecs[20] = mk(1'b1, 4'd4, 1'b1, 1'b0,  1'b0, 4'b0000, 1'b0, 4'd0, 1'b1);
    vecs[21] = mk(1'b1, 4'd4, 1'b1, 1'b0,  1'b0, 4'b0000, 1'b0, 4'd0, 1'b1);
    vecs[22] = mk(1'b1, 4'd4, 1'b1, 1'b0,  1'b0, 4'b0000, 1'b0, 4'd0, 1'b1);
    vecs[23] = mk(1'b1, 4'd4, 1'b1, 1'b1,  1'b0, 4'b0000, 1'b0, 4'd0, 1'b1);
    vecs[24] = mk(1'b0, 4'd0, 1'b1, 1'b0,  1'b1, 4'b0000, 1'b0, 4'd0, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready",    32'(in_ready),  32'd1);
    chk("rst_load_en",     32'(load_en),   32'd0);
    chk("rst_out_valid",   32'(out_valid), 32'd0);
    chk("rst_busy",        32'(busy),      32'd0);
    chk("rst_perf_frames", perf_frames,    32'd0);
    chk("rst_perf_stalls", perf_stalls,    32'd0);
    reset_n = 1'b1;

    // Vector table
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      in_valid  = vecs[i].iv;
      in_tag    = vecs[i].itag;
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      @(negedge clk);
      chk($sformatf("row%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_irdy));
      chk($sformatf("row%0d_load_en", i),   32'(load_en),   32'(vecs[i].e_ld));
      chk($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("row%0d_busy", i),      32'(busy),      32'(vecs[i].e_busy));
      if (vecs[i].e_ov)
        chk($sformatf("row%0d_out_tag", i), 32'(out_tag),   32'(vecs[i].e_otag));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;

    // Test 2: continuous stream of tags 0..7 with out_ready=1
    sent = 0; recv = 0; cyc = 0; last_out = 0;
    out_ready = 1'b1;
    while (recv < 8 && cyc < 300) begin
      @(posedge clk);
      #1;
      in_valid = (sent < 8);
      in_tag   = 4'(sent);
      @(negedge clk);
      cyc++;
      if (in_valid && in_ready) begin
        acc_cyc[sent] = cyc;
        sent++;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("t2_out_tag%0d", recv), 32'(out_tag), 32'(recv));
        if (recv == 0) chk("t2_latency_cycles", 32'(cyc - acc_cyc[0]), 32'd11);
        else           chk($sformatf("t2_out_spacing%0d", recv), 32'(cyc - last_out), 32'd4);
        last_out = cyc;
        recv++;
      end
    end
    chk("t2_all_received", 32'(recv), 32'd8);
    for (int k = 3; k < 8; k++)
      chk($sformatf("t2_accept_spacing%0d", k), 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd4);
    #1 in_valid = 1'b0;
    wait_idle("t2_idle", 50);

    // Test 3: backpressure, 6 frames offered, 4 fit
    sent = 0; recv = 0; stable_bad = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      in_valid = (sent < 6);
      in_tag   = 4'(8 + sent);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      if (out_valid && out_tag != 4'd8) stable_bad = 1'b1;
    end
    chk("t3_accepted",   32'(sent),       32'd4);
    chk("t3_in_ready",   32'(in_ready),   32'd0);
    chk("t3_busy",       32'(busy),       32'd1);
    chk("t3_out_valid",  32'(out_valid),  32'd1);
    chk("t3_out_tag",    32'(out_tag),    32'd8);
    chk("t3_tag_stable", 32'(stable_bad), 32'd0);
    cyc = 0;
    while (recv < 6 && cyc < 200) begin
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid  = (sent < 6);
      in_tag    = 4'(8 + sent);
      @(negedge clk);
      cyc++;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk($sformatf("t3_drain_tag%0d", recv), 32'(out_tag), 32'(8 + recv));
        recv++;
      end
    end
    chk("t3_all_drained", 32'(recv), 32'd6);
    #1 in_valid = 1'b0;
    wait_idle("t3_idle", 50);

    // Test 5: asynchronous reset while a result is held
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_tag   = 4'd7;
    @(negedge clk);
    chk("t5_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("t5_held_before_reset", 32'(out_valid), 32'd1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_busy",      32'(busy),      32'd0);
    chk("t5_rst_in_ready",  32'(in_ready),  32'd1);
    chk("t5_rst_load_en",   32'(load_en),   32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_tag   = 4'd9;
    @(negedge clk);
    chk("t5_new_load_en", 32'(load_en), 32'b0001);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (n < 30) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) break;
    end
    chk("t5_latency_edges", 32'(n), 32'd10);
    chk("t5_out_tag",       32'(out_tag), 32'd9);
    wait_idle("t5_idle", 20);

    // Test 6: perf counters, 2 frames and 3 stall cycles
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_perf_frames", perf_frames, 32'd0);
    chk("t6_rst_perf_stalls", perf_stalls, 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b0;
    sent = 0; cyc = 0;
    while (sent < 2 && cyc < 50) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_tag   = 4'(3 + sent);
      @(negedge clk);
      cyc++;
      if (in_ready) sent++;
    end
    chk("t6_accepted", 32'(sent), 32'd2);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t6_first_out", 32'(out_valid), 32'd1);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle("t6_idle", 40);
    @(negedge clk);
`ifdef LENET_SEQ_PERF_EN
    exp_frames = 32'd2;
    exp_stalls = 32'd3;
`else
    exp_frames = 32'd0;
    exp_stalls = 32'd0;
`endif
    chk("t6_perf_frames", perf_frames, exp_frames);
    chk("t6_perf_stalls", perf_stalls, exp_stalls);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
